// File: rtl/i2c_pkg.sv
// -----------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C write-only master:
//   - i2c_state_e : transaction state encoding
//   - Q0..Q3      : quarter-phase constants within one SCL bit period
//   - I2C_WR      : R/W bit value appended to the 7-bit device address
//   - line_drive  : maps (state, quarter, data bit) to the open-drain enables
// -----------------------------------------------------------------------------
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_ADDR  = 3'd2,
        ST_DATA  = 3'd3,
        ST_ACK   = 3'd4,
        ST_STOP  = 3'd5
    } i2c_state_e;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam logic I2C_WR = 1'b0;

    // Open-drain enables: 1 pulls the line low, 0 releases it.
    typedef struct packed {
        logic sda_oe;
        logic scl_oe;
    } i2c_lines_t;

    // Line levels for a given state and quarter. SCL is low in q0/q1 and
    // released in q2/q3 for every bit slot; START and STOP move SDA while
    // SCL is high, which is exactly what makes them START/STOP conditions.
    function automatic i2c_lines_t line_drive(input i2c_state_e st,
                                              input logic [1:0] q,
                                              input logic       bit_val);
        i2c_lines_t l;
        l.sda_oe = 1'b0;
        l.scl_oe = 1'b0;
        case (st)
            ST_IDLE: begin
                l.sda_oe = 1'b0;
                l.scl_oe = 1'b0;
            end
            ST_START: begin
                // q0/q1 released, q2 SDA falls with SCL high, q3 SCL low
                l.sda_oe = (q == Q2) || (q == Q3);
                l.scl_oe = (q == Q3);
            end
            ST_ADDR, ST_DATA: begin
                l.sda_oe = ~bit_val;
                l.scl_oe = (q == Q0) || (q == Q1);
            end
            ST_ACK: begin
                // SDA released so the slave can answer
                l.sda_oe = 1'b0;
                l.scl_oe = (q == Q0) || (q == Q1);
            end
            ST_STOP: begin
                // SDA held low until SCL is high, then released in q3
                l.sda_oe = (q != Q3);
                l.scl_oe = (q == Q0) || (q == Q1);
            end
            default: begin
                l.sda_oe = 1'b0;
                l.scl_oe = 1'b0;
            end
        endcase
        return l;
    endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// -----------------------------------------------------------------------------
// i2c_quarter_tick
// Divides clk by CLK_DIV to mark SCL quarter boundaries and tracks the
// 2-bit quarter phase within the current bit.
//
// Ports:
//   clk      : system clock
//   irst     : asynchronous active-high reset
//   en_i     : count while high; counter and phase are cleared while low
//   freeze_i : hold counter and phase (clock stretching by the slave)
//   qt_o     : high in the last clk cycle of a quarter (advance strobe)
//   phase_o  : current quarter phase, Q0..Q3
// -----------------------------------------------------------------------------
module i2c_quarter_tick
    import i2c_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2500
) (
    input  logic       clk,
    input  logic       irst,
    input  logic       en_i,
    input  logic       freeze_i,
    output logic       qt_o,
    output logic [1:0] phase_o
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic [1:0]       phase_q;
    logic [1:0]       phase_d;

    assign qt_o    = en_i && !freeze_i && (div_q == DIV_LAST);
    assign phase_o = phase_q;

    // Next divider/phase value: clear when idle, hold when frozen, else count.
    always_comb begin
        div_d   = div_q;
        phase_d = phase_q;
        if (!en_i) begin
            div_d   = '0;
            phase_d = Q0;
        end else if (freeze_i) begin
            div_d   = div_q;
            phase_d = phase_q;
        end else if (div_q == DIV_LAST) begin
            div_d   = '0;
            phase_d = phase_q + 2'd1;
        end else begin
            div_d   = div_q + {{(DIV_W-1){1'b0}}, 1'b1};
            phase_d = phase_q;
        end
    end

    // Divider and phase registers.
    always_ff @(posedge clk or posedge irst) begin
        if (irst) begin
            div_q   <= '0;
            phase_q <= Q0;
        end else begin
            div_q   <= div_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/i2c_write_master.sv
// -----------------------------------------------------------------------------
// i2c_write_master
// Write-only I2C master: START, {DEV_ADDR, W}, NUM_BYTES data bytes (ACK
// checked after each), STOP. A NACK aborts straight to STOP. SDA/SCL are
// driven open-drain through output enables.
//
// Optional feature macro: I2C_CLOCK_STRETCH_EN
//   defined   : while SCL is released in q2/q3, the divider freezes as long
//               as scl_i reads low (slave clock stretching)
//   undefined : scl_i is ignored, timing is purely counter driven
//
// Ports:
//   clk      : system clock, rising edge
//   irst     : asynchronous active-high reset (releases both lines at once)
//   start    : transaction request, accepted only in IDLE
//   data_in  : payload, byte [8*NUM_BYTES-1 -: 8] sent first, MSB first
//   sda_i    : SDA pad input (ACK sampling)
//   sda_oe   : 1 pulls SDA low
//   scl_i    : SCL pad input (stretch detection only)
//   scl_oe   : 1 pulls SCL low
//   busy     : transaction in progress
//   done     : one-cycle pulse in the first idle cycle after a transaction
//   nack     : last transaction aborted on a NACK
//   ack_vec  : bit k set when byte k was ACKed (bit 0 = address byte)
// -----------------------------------------------------------------------------
module i2c_write_master
    import i2c_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 2500,
    parameter int unsigned NUM_BYTES = 2,
    parameter logic [6:0]  DEV_ADDR  = 7'h1A
) (
    input  logic                   clk,
    input  logic                   irst,
    input  logic                   start,
    input  logic [8*NUM_BYTES-1:0] data_in,
    input  logic                   sda_i,
    output logic                   sda_oe,
    input  logic                   scl_i,
    output logic                   scl_oe,
    output logic                   busy,
    output logic                   done,
    output logic                   nack,
    output logic [NUM_BYTES:0]     ack_vec
);

    localparam int unsigned SR_W      = 8 * (NUM_BYTES + 1);
    localparam logic [2:0]  LAST_BYTE = 3'(NUM_BYTES);
    localparam logic [2:0]  LAST_BIT  = 3'd7;

    i2c_state_e           state_q;
    i2c_state_e           state_d;
    logic [SR_W-1:0]      sreg_q;
    logic [SR_W-1:0]      sreg_d;
    logic [2:0]           bit_cnt_q;
    logic [2:0]           bit_cnt_d;
    logic [2:0]           byte_cnt_q;
    logic [2:0]           byte_cnt_d;
    logic                 busy_q;
    logic                 done_q;
    logic                 done_d;
    logic                 nack_q;
    logic                 nack_d;
    logic [NUM_BYTES:0]   ack_q;
    logic [NUM_BYTES:0]   ack_d;
    logic                 sda_oe_q;
    logic                 scl_oe_q;

    logic                 qt_s;
    logic [1:0]           phase_s;
    logic [1:0]           phase_nx_s;
    logic                 end_bit_s;
    logic                 freeze_s;
    i2c_lines_t           lines_s;

`ifdef I2C_CLOCK_STRETCH_EN
    // Only stretch while we are not pulling SCL ourselves; otherwise our own
    // low SCL (e.g. START q3) would look like a stretching slave.
    assign freeze_s = busy_q && !scl_oe_q && !scl_i &&
                      ((phase_s == Q2) || (phase_s == Q3));
`else
    logic unused_scl_s;
    assign unused_scl_s = scl_i;
    assign freeze_s     = 1'b0;
`endif

    i2c_quarter_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk      (clk),
        .irst     (irst),
        .en_i     (busy_q),
        .freeze_i (freeze_s),
        .qt_o     (qt_s),
        .phase_o  (phase_s)
    );

    // Phase that will be current in the next cycle; line enables are
    // registered from next-state values so they line up with busy.
    assign phase_nx_s = qt_s ? (phase_s + 2'd1) : phase_s;
    assign end_bit_s  = qt_s && (phase_s == Q3);

    // Transaction sequencing: state, counters, shift register and status.
    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        nack_d     = nack_q;
        ack_d      = ack_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_START;
                    sreg_d     = {DEV_ADDR, I2C_WR, data_in};
                    bit_cnt_d  = 3'd0;
                    byte_cnt_d = 3'd0;
                    nack_d     = 1'b0;
                    ack_d      = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (end_bit_s) begin
                    state_d = ST_ADDR;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_ADDR, ST_DATA: begin
                if (end_bit_s) begin
                    // MSB of the shift register is always the bit on the wire
                    sreg_d = {sreg_q[SR_W-2:0], 1'b0};
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = 3'd0;
                        state_d   = ST_ACK;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_ACK: begin
                if (end_bit_s) begin
                    if (!sda_i) begin
                        for (int unsigned k = 0; k <= NUM_BYTES; k++) begin
                            if (byte_cnt_q == 3'(k)) begin
                                ack_d[k] = 1'b1;
                            end else begin
                                ack_d[k] = ack_q[k];
                            end
                        end
                        if (byte_cnt_q == LAST_BYTE) begin
                            state_d = ST_STOP;
                        end else begin
                            byte_cnt_d = byte_cnt_q + 3'd1;
                            state_d    = ST_DATA;
                        end
                    end else begin
                        nack_d  = 1'b1;
                        state_d = ST_STOP;
                    end
                end else begin
                    state_d = ST_ACK;
                end
            end
            ST_STOP: begin
                if (end_bit_s) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        lines_s = line_drive(state_d, (state_d == ST_IDLE) ? Q0 : phase_nx_s,
                             sreg_d[SR_W-1]);
    end

    // State and registered outputs; async reset releases the bus at once.
    always_ff @(posedge clk or posedge irst) begin
        if (irst) begin
            state_q    <= ST_IDLE;
            sreg_q     <= '0;
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= 3'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            nack_q     <= 1'b0;
            ack_q      <= '0;
            sda_oe_q   <= 1'b0;
            scl_oe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            sreg_q     <= sreg_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            busy_q     <= (state_d != ST_IDLE);
            done_q     <= done_d;
            nack_q     <= nack_d;
            ack_q      <= ack_d;
            sda_oe_q   <= lines_s.sda_oe;
            scl_oe_q   <= lines_s.scl_oe;
        end
    end

    assign sda_oe  = sda_oe_q;
    assign scl_oe  = scl_oe_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign nack    = nack_q;
    assign ack_vec = ack_q;

endmodule

// File: tb/tb_i2c_write_master.sv
// -----------------------------------------------------------------------------
// tb_i2c_write_master
// Self-checking bench. A behavioural model turns each transaction into the
// expected per-cycle bus picture (quarters expanded by CLK_DIV) and a single
// negedge process compares the DUT against it; a bus monitor decodes the
// bytes seen on the wire for hand-computed spot checks.
// -----------------------------------------------------------------------------
module tb_i2c_write_master;

    localparam int         CLK_DIV = 4;
    localparam int         NB      = 2;
    localparam logic [6:0] DEV     = 7'h1A;

    logic        clk = 1'b0;
    logic        irst;
    logic        start;
    logic [15:0] data_in;
    logic        sda_i;
    logic        sda_oe;
    logic        scl_i;
    logic        scl_oe;
    logic        busy;
    logic        done;
    logic        nack;
    logic [2:0]  ack_vec;

    logic        pull_r      = 1'b0;   // slave pulling SDA low
    logic        stretch_low = 1'b0;   // slave holding SCL low

    assign sda_i = ~(sda_oe | pull_r);
    assign scl_i = ~(scl_oe | stretch_low);

    always #5 clk = ~clk;

    i2c_write_master #(
        .CLK_DIV   (CLK_DIV),
        .NUM_BYTES (NB),
        .DEV_ADDR  (DEV)
    ) dut (
        .clk     (clk),
        .irst    (irst),
        .start   (start),
        .data_in (data_in),
        .sda_i   (sda_i),
        .sda_oe  (sda_oe),
        .scl_i   (scl_i),
        .scl_oe  (scl_oe),
        .busy    (busy),
        .done    (done),
        .nack    (nack),
        .ack_vec (ack_vec)
    );

    typedef struct packed {
        logic       sda;
        logic       scl;
        logic       busy;
        logic       done;
        logic       nack;
        logic [2:0] ackv;
        logic       pull;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;
    logic cmp_en = 1'b0;
    logic last_nack = 1'b0;
    logic [2:0] last_ack = 3'b000;
    int   busy_run = 0;
    int   last_busy_len = 0;
    int   done_cnt = 0;
    logic prev_sda = 1'b1;
    logic prev_scl = 1'b1;
    logic wire_bits[$];
    exp_t e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One quarter of CLK_DIV identical cycles.
    task automatic add_q(input logic sda, input logic scl, input logic pull);
        exp_t x;
        x.sda = sda; x.scl = scl; x.busy = 1'b1; x.done = 1'b0;
        x.nack = 1'b0; x.ackv = 3'b000; x.pull = pull;
        for (int i = 0; i < CLK_DIV; i++) expq.push_back(x);
    endtask

    // Model: expected bus picture for one transaction.
    task automatic push_txn(input logic [15:0] d, input logic [2:0] ack_mask, input int stretch);
        logic [23:0] frame;
        logic        nk;
        logic [2:0]  av;
        logic        b;
        int          base;
        exp_t        x;
        frame = {DEV, 1'b0, d};
        nk = 1'b0;
        av = 3'b000;
        base = expq.size();
        add_q(1'b0, 1'b0, 1'b0); add_q(1'b0, 1'b0, 1'b0);
        add_q(1'b1, 1'b0, 1'b0); add_q(1'b1, 1'b1, 1'b0);
        for (int k = 0; k <= NB; k++) begin
            for (int i = 0; i < 8; i++) begin
                b = frame[23 - 8*k - i];
                add_q(!b, 1'b1, 1'b0); add_q(!b, 1'b1, 1'b0);
                add_q(!b, 1'b0, 1'b0); add_q(!b, 1'b0, 1'b0);
            end
            add_q(1'b0, 1'b1, ack_mask[k]); add_q(1'b0, 1'b1, ack_mask[k]);
            add_q(1'b0, 1'b0, ack_mask[k]); add_q(1'b0, 1'b0, ack_mask[k]);
            if (!ack_mask[k]) begin
                nk = 1'b1;
                break;
            end
            av[k] = 1'b1;
        end
        add_q(1'b1, 1'b1, 1'b0); add_q(1'b1, 1'b1, 1'b0);
        add_q(1'b1, 1'b0, 1'b0); add_q(1'b0, 1'b0, 1'b0);
        x.sda = 1'b0; x.scl = 1'b0; x.busy = 1'b0; x.done = 1'b1;
        x.nack = nk; x.ackv = av; x.pull = 1'b0;
        expq.push_back(x);
        // a stretched first-address-bit q2 simply repeats its first cycle
        x = expq[base + 6*CLK_DIV];
        for (int i = 0; i < stretch; i++) expq.insert(base + 6*CLK_DIV, x);
        last_nack = nk;
        last_ack  = av;
    endtask

    // Per-cycle compare, slave ACK drive, busy-length and wire monitor.
    always @(negedge clk) begin
        if (cmp_en) begin
            if (expq.size() > 0) begin
                e = expq.pop_front();
                pull_r <= e.pull;
                chk("sda_oe", 32'(sda_oe), 32'(e.sda));
                chk("scl_oe", 32'(scl_oe), 32'(e.scl));
                chk("busy", 32'(busy), 32'(e.busy));
                chk("done", 32'(done), 32'(e.done));
                if (e.done) begin
                    chk("nack_at_done", 32'(nack), 32'(e.nack));
                    chk("ack_vec_at_done", 32'(ack_vec), 32'(e.ackv));
                end
            end else begin
                pull_r <= 1'b0;
                chk("idle_sda_oe", 32'(sda_oe), 32'd0);
                chk("idle_scl_oe", 32'(scl_oe), 32'd0);
                chk("idle_busy", 32'(busy), 32'd0);
                chk("idle_done", 32'(done), 32'd0);
                chk("idle_nack", 32'(nack), 32'(last_nack));
                chk("idle_ack_vec", 32'(ack_vec), 32'(last_ack));
            end
        end
        if (busy) begin
            busy_run = busy_run + 1;
        end else if (busy_run > 0) begin
            last_busy_len = busy_run;
            busy_run = 0;
        end
        if (done) done_cnt = done_cnt + 1;
        if (!prev_scl && scl_i) wire_bits.push_back(sda_i);
        if (prev_scl && scl_i && prev_sda && !sda_i) wire_bits.delete();
        prev_scl = scl_i;
        prev_sda = sda_i;
    end

    task automatic begin_txn(input logic [15:0] d, input logic [2:0] mask, input int stretch);
        @(posedge clk); #1;
        data_in = d;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        push_txn(d, mask, stretch);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (expq.size() > 0 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        if (expq.size() > 0) begin
            errors++;
            $display("FAIL wait_idle: actual %0d entries left expected 0", expq.size());
            expq.delete();
        end
        @(posedge clk); #1;
    endtask

    // Decoded wire bytes (each followed by its ACK slot) against a frame.
    task automatic chk_wire(input string name, input logic [23:0] frame, input int nbytes);
        logic [7:0] b;
        if (wire_bits.size() < 9*nbytes) begin
            checks++;
            errors++;
            $display("FAIL %s: actual %0d wire bits expected at least %0d", name, wire_bits.size(), 9*nbytes);
        end else begin
            for (int k = 0; k < nbytes; k++) begin
                for (int i = 0; i < 8; i++) b[7-i] = wire_bits[9*k + i];
                chk(name, 32'(b), 32'(frame[23 - 8*k -: 8]));
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        int r;
        logic [2:0] m;
        logic seen;
        irst    = 1'b1;
        start   = 1'b0;
        data_in = 16'h0000;
        repeat (3) @(negedge clk);
        chk("rst_sda_oe", 32'(sda_oe), 32'd0);
        chk("rst_scl_oe", 32'(scl_oe), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_nack", 32'(nack), 32'd0);
        chk("rst_ack_vec", 32'(ack_vec), 32'd0);
        @(posedge clk); #1;
        irst   = 1'b0;
        cmp_en = 1'b1;
        repeat (3) @(posedge clk);

        // all bytes ACKed
        dc = done_cnt;
        begin_txn(16'h1E00, 3'b111, 0);
        wait_idle();
        chk("full_busy_len", 32'(last_busy_len), 32'd464);
        chk("full_ack_vec", 32'(ack_vec), 32'h7);
        chk("full_nack", 32'(nack), 32'd0);
        chk("full_done_pulses", 32'(done_cnt - dc), 32'd1);
        chk_wire("full_wire_byte", 24'h341E00, 3);
        chk("full_wire_ack0", 32'(wire_bits[8]), 32'd0);

        // address NACKed
        begin_txn(16'hBEEF, 3'b000, 0);
        wait_idle();
        chk("nack_addr_busy_len", 32'(last_busy_len), 32'd176);
        chk("nack_addr_ack_vec", 32'(ack_vec), 32'h0);
        chk("nack_addr_nack", 32'(nack), 32'd1);

        // first data byte NACKed
        begin_txn(16'h5AC3, 3'b101, 0);
        wait_idle();
        chk("nack_b1_busy_len", 32'(last_busy_len), 32'd320);
        chk("nack_b1_ack_vec", 32'(ack_vec), 32'h1);
        chk("nack_b1_nack", 32'(nack), 32'd1);
        chk_wire("nack_b1_wire_byte", 24'h345A00, 2);

        // start held through busy, re-accepted in the done cycle
        dc = done_cnt;
        @(posedge clk); #1;
        data_in = 16'h1234;
        start = 1'b1;
        @(posedge clk); #1;
        push_txn(16'h1234, 3'b111, 0);
        data_in = 16'hA55A;
        seen = 1'b0;
        for (int n = 0; n < 2000 && !seen; n++) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        chk("b2b_first_done", 32'(seen), 32'd1);
        @(posedge clk); #1;
        start = 1'b0;
        push_txn(16'hA55A, 3'b111, 0);
        wait_idle();
        chk("b2b_done_pulses", 32'(done_cnt - dc), 32'd2);
        chk_wire("b2b_wire_byte", 24'h34A55A, 3);

        // randomized payloads and slave answers
        for (int t = 0; t < 6; t++) begin
            r = $urandom_range(0, 3);
            m = (r == 0) ? 3'($urandom_range(0, 7)) : 3'b111;
            begin_txn(16'($urandom), m, 0);
            wait_idle();
        end

        // async reset in the middle of the first data byte
        dc = done_cnt;
        begin_txn(16'hC3C3, 3'b111, 0);
        repeat (232) @(negedge clk);
        #2;
        irst = 1'b1;
        expq.delete();
        last_nack = 1'b0;
        last_ack  = 3'b000;
        #1;
        chk("rst_mid_sda_oe", 32'(sda_oe), 32'd0);
        chk("rst_mid_scl_oe", 32'(scl_oe), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        irst = 1'b0;
        repeat (20) @(posedge clk);
        chk("rst_mid_no_done", 32'(done_cnt - dc), 32'd0);

`ifdef I2C_CLOCK_STRETCH_EN
        // slave holds SCL low for 20 cycles from the first address bit's q2
        begin_txn(16'h1E00, 3'b111, 20);
        repeat (6*CLK_DIV - 1) @(posedge clk);
        #1;
        stretch_low = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        stretch_low = 1'b0;
        wait_idle();
        chk("stretch_busy_len", 32'(last_busy_len), 32'd484);
        chk_wire("stretch_wire_byte", 24'h341E00, 3);
`endif

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
